// File: rtl/rf_wb_sched_pkg.sv
// rf_wb_sched_pkg
//   Shared CPU constants and types for the register-file write-back path.
//   REG_NUM / REG_AW : register count and address width
//   WEN_W / DATA_W   : byte-enable and data widths of the RF write port
//   wb_src_e         : requester index (WB_PIPE = in-order pipeline,
//                      WB_MULTI = multi-cycle unit)
package rf_wb_sched_pkg;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned WEN_W   = 4;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic {
        WB_PIPE  = 1'b0,
        WB_MULTI = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_wb_sched_arb.sv
// wb_rr_arb2
//   Two-input round-robin arbiter for the register-file write port.
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request valids (index WB_PIPE / WB_MULTI)
//   gnt[1:0]   : combinational one-hot-or-zero grants
//   After any grant the priority moves to the requester that lost.
module wb_rr_arb2
    import rf_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e prio;
    wb_src_e prio_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= WB_PIPE;
        end else begin
            prio <= prio_nxt;
        end
    end

    // Grants are masked while reset is high so nothing is accepted that
    // would be lost anyway.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            gnt[WB_PIPE]  = req[WB_PIPE]  & (~req[WB_MULTI] | (prio == WB_PIPE));
            gnt[WB_MULTI] = req[WB_MULTI] & (~req[WB_PIPE]  | (prio == WB_MULTI));
        end
    end

    always_comb begin
        prio_nxt = prio;
        if (gnt[WB_PIPE]) begin
            prio_nxt = WB_MULTI;
        end else if (gnt[WB_MULTI]) begin
            prio_nxt = WB_PIPE;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched
//   Write-back scheduler sharing the register file's single write port
//   between the pipeline (req0) and the multi-cycle unit (req1), with a
//   per-register pending-write scoreboard for decode.
//   clk, reset                     : clock, asynchronous active-high reset
//   req{0,1}_valid/addr/wen/data   : write-back requests
//   req{0,1}_ready                 : request accepted this cycle (comb)
//   sb_set, sb_addr                : decode issues a writer of sb_addr
//   sb_ready                       : sb_addr counter not saturated (comb)
//   raddr1, raddr2 / busy1, busy2  : source register pending-write status
//   rf_waddr, rf_wen, rf_wdata     : registered register-file write port
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [REG_AW-1:0] req0_addr,
    input  logic [WEN_W-1:0]  req0_wen,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [REG_AW-1:0] req1_addr,
    input  logic [WEN_W-1:0]  req1_wen,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              sb_set,
    input  logic [REG_AW-1:0] sb_addr,
    output logic              sb_ready,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [WEN_W-1:0]  rf_wen,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        gnt;
    logic              gnt_any;
    logic [REG_AW-1:0] gnt_addr;
    logic [WEN_W-1:0]  gnt_wen;
    logic [DATA_W-1:0] gnt_data;

    // Register 0 has no counter; indices run 1..REG_NUM-1.
    logic [CNT_W-1:0] cnt     [1:REG_NUM-1];
    logic [CNT_W-1:0] cnt_nxt [1:REG_NUM-1];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    wb_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[WB_PIPE];
    assign req1_ready = gnt[WB_MULTI];
    assign gnt_any    = |gnt;

    always_comb begin
        gnt_addr = req0_addr;
        gnt_wen  = req0_wen;
        gnt_data = req0_data;
        if (gnt[WB_MULTI]) begin
            gnt_addr = req1_addr;
            gnt_wen  = req1_wen;
            gnt_data = req1_data;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: address/data hold between grants, wen pulses only on
    // a grant and is suppressed for register 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_waddr <= '0;
            rf_wen   <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= '0;
            if (gnt_any) begin
                rf_waddr <= gnt_addr;
                rf_wdata <= gnt_data;
                rf_wen   <= (gnt_addr == '0) ? '0 : gnt_wen;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard lookups (combinational from current counters)
    // ------------------------------------------------------------------
    always_comb begin
        sb_ready = 1'b1;
        busy1    = 1'b0;
        busy2    = 1'b0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if ((sb_addr == REG_AW'(i)) && (cnt[i] == CNT_MAX)) begin
                sb_ready = 1'b0;
            end
            if ((raddr1 == REG_AW'(i)) && (cnt[i] != '0)) begin
                busy1 = 1'b1;
            end
            if ((raddr2 == REG_AW'(i)) && (cnt[i] != '0)) begin
                busy2 = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard update. Increment only when not saturated; decrement on
    // any grant (even one with wen 0000) unless already zero. Both in the
    // same cycle cancel out.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            logic inc;
            logic dec;
            inc = sb_set & sb_ready & (sb_addr == REG_AW'(i));
            dec = gnt_any & (gnt_addr == REG_AW'(i)) & (cnt[i] != '0);
            cnt_nxt[i] = cnt[i];
            if (inc && !dec) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched
//   Directed bench for rf_wb_sched. Expected register-file writes are
//   queued by the stimulus and checked by a negedge monitor; combinational
//   outputs (readies, busy, sb_ready) are checked inline.
module tb_rf_wb_sched;

    typedef struct packed {
        logic [4:0]  a;
        logic [3:0]  w;
        logic [31:0] d;
    } wr_t;

    bit          clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [3:0]  req0_wen, req1_wen;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        sb_set, sb_ready;
    logic [4:0]  sb_addr, raddr1, raddr2;
    logic        busy1, busy2;
    logic [4:0]  rf_waddr;
    logic [3:0]  rf_wen;
    logic [31:0] rf_wdata;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    wr_t exp_q[$];

    rf_wb_sched #(.CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_wen   (req0_wen),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_wen   (req1_wen),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .sb_ready   (sb_ready),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .rf_waddr   (rf_waddr),
        .rf_wen     (rf_wen),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests, check readies, queue expected writes
    // for the granted side(s), then advance past the clock edge.
    task automatic cyc(input string nm,
                       input bit v0, input logic [4:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                       input bit e0, input bit e1);
        req0_valid = v0; req0_addr = a0; req0_wen = w0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_wen = w1; req1_data = d1;
        #1;
        chk({nm, "_rdy0"}, 32'(req0_ready), 32'(e0));
        chk({nm, "_rdy1"}, 32'(req1_ready), 32'(e1));
        if (e0 && a0 != 5'd0) exp_q.push_back('{a: a0, w: w0, d: d0});
        if (e1 && a1 != 5'd0) exp_q.push_back('{a: a1, w: w1, d: d1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc("idle", 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: every write pulse on the port must match the next queued one.
    always @(negedge clk) begin
        if (reset !== 1'b1 && rf_wen !== 4'h0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d wen 0x%h data 0x%08h, expected none",
                         rf_waddr, rf_wen, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("mon_addr", 32'(rf_waddr), 32'(e.a));
                chk("mon_wen",  32'(rf_wen),   32'(e.w));
                chk("mon_data", rf_wdata,      e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_wen = 4'hF; req0_data = 32'h1111_2222;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_wen = 4'h0; req1_data = 32'h0;
        sb_set = 1'b0; sb_addr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd9;

        // Reset: nothing accepted, outputs cleared
        #3;
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        step();
        chk("rst_wen",   32'(rf_wen),   32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata,      32'd0);
        chk("rst_sbrdy", 32'(sb_ready), 32'd1);
        reset = 1'b0;

        // First grant after release (prio 0 -> 1)
        cyc("rel", 1'b1, 5'd5, 4'hF, 32'h1111_2222, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        // Partial write from req1 (prio 1 -> 0)
        cyc("part", 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd10, 4'b0011, 32'h1234_5678, 1'b0, 1'b1);

        // Contention: grants 0,1,0,1
        cyc("cont0", 1'b1, 5'd3, 4'hF, 32'hAAAA_0000, 1'b1, 5'd4, 4'hF, 32'h5555_FFFF, 1'b1, 1'b0);
        cyc("cont1", 1'b1, 5'd3, 4'hF, 32'hAAAA_0000, 1'b1, 5'd4, 4'hF, 32'h5555_FFFF, 1'b0, 1'b1);
        cyc("cont2", 1'b1, 5'd3, 4'hF, 32'hAAAA_0000, 1'b1, 5'd4, 4'hF, 32'h5555_FFFF, 1'b1, 1'b0);
        cyc("cont3", 1'b1, 5'd3, 4'hF, 32'hAAAA_0000, 1'b1, 5'd4, 4'hF, 32'h5555_FFFF, 1'b0, 1'b1);
        idle();

        // Scoreboard saturation on r7
        chk("r7_pre_busy", 32'(busy1), 32'd0);
        chk("r7_pre_sbrdy", 32'(sb_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            sb_set = 1'b1;
            step();
        end
        sb_set = 1'b0;
        #1;
        chk("r7_sat_busy", 32'(busy1), 32'd1);
        chk("r7_sat_sbrdy", 32'(sb_ready), 32'd0);
        sb_set = 1'b1;
        step();
        sb_set = 1'b0;
        #1;
        chk("r7_4th_busy", 32'(busy1), 32'd1);
        chk("r7_4th_sbrdy", 32'(sb_ready), 32'd0);
        cyc("r7w1", 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 4'hF, 32'h7000_0001, 1'b0, 1'b1);
        chk("r7w1_busy", 32'(busy1), 32'd1);
        chk("r7w1_sbrdy", 32'(sb_ready), 32'd1);
        cyc("r7w2", 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 4'hF, 32'h7000_0002, 1'b0, 1'b1);
        chk("r7w2_busy", 32'(busy1), 32'd1);
        cyc("r7w3", 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 4'hF, 32'h7000_0003, 1'b0, 1'b1);
        chk("r7w3_busy", 32'(busy1), 32'd0);
        idle();

        // Simultaneous set and grant on r9
        sb_addr = 5'd9;
        sb_set = 1'b1;
        step();
        sb_set = 1'b0;
        #1;
        chk("r9_busy", 32'(busy2), 32'd1);
        chk("r9_sbrdy", 32'(sb_ready), 32'd1);
        sb_set = 1'b1;
        cyc("r9_same", 1'b1, 5'd9, 4'hF, 32'h9000_0009, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        sb_set = 1'b0;
        chk("r9_same_busy", 32'(busy2), 32'd1);
        cyc("r9_last", 1'b1, 5'd9, 4'hF, 32'h9000_000A, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk("r9_last_busy", 32'(busy2), 32'd0);
        idle();

        // Register 0: no write enable, never busy, never saturates
        sb_addr = 5'd0;
        raddr1 = 5'd0;
        sb_set = 1'b1;
        #1;
        chk("r0_sbrdy", 32'(sb_ready), 32'd1);
        cyc("r0", 1'b1, 5'd0, 4'hF, 32'hFFFF_0000, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk("r0_wen", 32'(rf_wen), 32'd0);
        chk("r0_waddr", 32'(rf_waddr), 32'd0);
        chk("r0_busy", 32'(busy1), 32'd0);
        chk("r0_sbrdy2", 32'(sb_ready), 32'd1);
        sb_set = 1'b0;
        idle();

        // Reset mid-operation: counter, output write and prio all cleared
        sb_addr = 5'd13;
        raddr1 = 5'd13;
        sb_set = 1'b1;
        step();
        sb_set = 1'b0;
        #1;
        chk("r13_busy", 32'(busy1), 32'd1);
        req0_valid = 1'b1; req0_addr = 5'd12; req0_wen = 4'hF; req0_data = 32'hDEAD_0001;
        #1;
        chk("mid_rdy0", 32'(req0_ready), 32'd1);
        step();
        reset = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_wen = 4'hF; req1_data = 32'h5555_FFFF;
        #1;
        chk("mid_wen", 32'(rf_wen), 32'd0);
        chk("mid_busy", 32'(busy1), 32'd0);
        chk("mid_rdy0", 32'(req0_ready), 32'd0);
        chk("mid_rdy1", 32'(req1_ready), 32'd0);
        step();
        reset = 1'b0;
        cyc("post_rst", 1'b1, 5'd3, 4'hF, 32'hAAAA_0000, 1'b1, 5'd4, 4'hF, 32'h5555_FFFF, 1'b1, 1'b0);
        idle();
        idle();

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
